// File: rtl/modmul_vec_ctrl_if.sv
// Command, SRAM and mod_mul handshake bundle for modmul_vec_ctrl.
// master: controller view; slave: command block / SRAM / mod_mul lane view.
interface modmul_vec_ctrl_if #(
    parameter int NBITS = 128,
    parameter int ABITS = 12
);
    logic               start_p;
    logic               nmul_cfg;
    logic [ABITS:0]     len;
    logic [ABITS-1:0]   src_a_base;
    logic [ABITS-1:0]   src_b_base;
    logic [ABITS-1:0]   dst_base;
    logic               busy;
    logic               done_p;
    logic               err_timeout;
    logic               rd_en;
    logic [ABITS-1:0]   rd_addr_a;
    logic [ABITS-1:0]   rd_addr_b;
    logic [NBITS-1:0]   rd_data_a;
    logic [NBITS-1:0]   rd_data_b;
    logic               wr_en;
    logic [ABITS-1:0]   wr_addr;
    logic [2*NBITS-1:0] wr_data;
    logic               mm_enable_p;
    logic               mm_nmul;
    logic [NBITS-1:0]   mm_a;
    logic [NBITS-1:0]   mm_b;
    logic [NBITS-1:0]   mm_y;
    logic [2*NBITS-1:0] mm_y_nom_mul;
    logic               mm_done_irq_p;

    modport master (
        input  start_p, nmul_cfg, len, src_a_base, src_b_base, dst_base,
               rd_data_a, rd_data_b, mm_y, mm_y_nom_mul, mm_done_irq_p,
        output busy, done_p, err_timeout, rd_en, rd_addr_a, rd_addr_b,
               wr_en, wr_addr, wr_data, mm_enable_p, mm_nmul, mm_a, mm_b
    );

    modport slave (
        output start_p, nmul_cfg, len, src_a_base, src_b_base, dst_base,
               rd_data_a, rd_data_b, mm_y, mm_y_nom_mul, mm_done_irq_p,
        input  busy, done_p, err_timeout, rd_en, rd_addr_a, rd_addr_b,
               wr_en, wr_addr, wr_data, mm_enable_p, mm_nmul, mm_a, mm_b
    );
endinterface

// File: rtl/modmul_vec_ctrl.sv
// Element-wise vector multiply sequencer driving one mod_mul lane from dual-port operand SRAM.
// Optional done watchdog enabled by defining MODMUL_VEC_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | waiting for start_p
//  RD    | SRAM read of a[i], b[i]
//  LOAD  | capture read data into mm_a/mm_b
//  FIRE  | mm_enable_p pulse
//  WAIT  | waiting for mm_done_irq_p (watchdog runs here when enabled)
//  WR    | write y[i], advance index
//  DONE  | done_p pulse
module modmul_vec_ctrl #(
    parameter int NBITS     = 128,
    parameter int ABITS     = 12,
    parameter int TO_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    modmul_vec_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_LOAD, S_FIRE, S_WAIT, S_WR, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ABITS:0]     len_q;
    logic [ABITS:0]     idx_q;
    logic [ABITS-1:0]   a_base_q, b_base_q, dst_base_q;
    logic               nmul_q;
    logic [NBITS-1:0]   mm_a_q, mm_b_q;
    logic [2*NBITS-1:0] res_q;
    logic               err_q;
    logic               timeout;
    logic               last_elem;

    assign last_elem = (idx_q + (ABITS+1)'(1)) >= len_q;

`ifdef MODMUL_VEC_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] to_cnt_q;

    // Loaded in FIRE so WAIT gets exactly TO_CYCLES cycles before terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q == S_FIRE) begin
            to_cnt_q <= CW'(TO_CYCLES - 1);
        end else if (state_q == S_WAIT && to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - CW'(1);
        end
    end

    assign timeout = (state_q == S_WAIT) && !bus.mm_done_irq_p && (to_cnt_q == '0);
`else
    localparam int to_cycles_unused = TO_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start_p) state_d = (bus.len == '0) ? S_DONE : S_RD;
            S_RD:    state_d = S_LOAD;
            S_LOAD:  state_d = S_FIRE;
            S_FIRE:  state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mm_done_irq_p) state_d = S_WR;
                else if (timeout)      state_d = S_DONE;
            end
            S_WR:    state_d = last_elem ? S_DONE : S_RD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            idx_q      <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            dst_base_q <= '0;
            nmul_q     <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == S_IDLE && bus.start_p) begin
                len_q      <= bus.len;
                a_base_q   <= bus.src_a_base;
                b_base_q   <= bus.src_b_base;
                dst_base_q <= bus.dst_base;
                nmul_q     <= bus.nmul_cfg;
                idx_q      <= '0;
                err_q      <= 1'b0;
            end
            if (state_q == S_LOAD) begin
                mm_a_q <= bus.rd_data_a;
                mm_b_q <= bus.rd_data_b;
            end
            // Result is only valid in the done cycle, so hold it for the WR cycle.
            if (state_q == S_WAIT && bus.mm_done_irq_p) begin
                res_q <= nmul_q ? bus.mm_y_nom_mul : {{NBITS{1'b0}}, bus.mm_y};
            end
            if (state_q == S_WR) begin
                idx_q <= idx_q + (ABITS+1)'(1);
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.busy        = (state_q != S_IDLE);
        bus.done_p      = (state_q == S_DONE);
        bus.rd_en       = (state_q == S_RD);
        bus.wr_en       = (state_q == S_WR);
        bus.mm_enable_p = (state_q == S_FIRE);
        bus.rd_addr_a   = '0;
        bus.rd_addr_b   = '0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        if (state_q == S_RD) begin
            bus.rd_addr_a = a_base_q + idx_q[ABITS-1:0];
            bus.rd_addr_b = b_base_q + idx_q[ABITS-1:0];
        end
        if (state_q == S_WR) begin
            bus.wr_addr = dst_base_q + idx_q[ABITS-1:0];
            bus.wr_data = res_q;
        end
    end

    assign bus.err_timeout = err_q;
    assign bus.mm_nmul     = nmul_q;
    assign bus.mm_a        = mm_a_q;
    assign bus.mm_b        = mm_b_q;
endmodule

// File: tb/tb_modmul_vec_ctrl.sv
// Directed bench for modmul_vec_ctrl with SRAM and mod_mul (m=97) behavioural models.
`timescale 1ns/1ps
module tb_modmul_vec_ctrl;
    localparam int NBITS = 128;
    localparam int ABITS = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modmul_vec_ctrl_if #(.NBITS(NBITS), .ABITS(ABITS)) bus();

    modmul_vec_ctrl #(.NBITS(NBITS), .ABITS(ABITS), .TO_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Operand SRAM: one-cycle read latency
    logic [NBITS-1:0] mem [0:(1<<ABITS)-1];
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem[bus.rd_addr_a];
            bus.rd_data_b <= mem[bus.rd_addr_b];
        end
    end

    // mod_mul lane model
    logic               model_done = 1'b0;
    logic               stray_done = 1'b0;
    logic               model_hang = 1'b0;
    logic               mbusy = 1'b0;
    int                 model_lat = 3;
    int                 lat_cnt = 0;
    logic [2*NBITS-1:0] prod = '0;
    logic [2*NBITS-1:0] modulus = 256'd97;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_done <= 1'b0;
            mbusy      <= 1'b0;
            lat_cnt    <= 0;
        end else begin
            model_done <= 1'b0;
            if (bus.mm_enable_p) begin
                mbusy   <= !model_hang;
                lat_cnt <= model_lat;
                prod    <= {{NBITS{1'b0}}, bus.mm_a} * {{NBITS{1'b0}}, bus.mm_b};
            end else if (mbusy) begin
                if (lat_cnt <= 1) begin
                    model_done <= 1'b1;
                    mbusy      <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end
    assign bus.mm_done_irq_p = model_done | stray_done;
    assign bus.mm_y_nom_mul  = prod;
    assign bus.mm_y          = NBITS'(prod % modulus);

    // Activity monitor
    int n_wr = 0, n_rd = 0, n_fire = 0, n_done = 0, n_overlap = 0, n_unstable = 0;
    logic [ABITS-1:0]   wr_addr_log [16];
    logic [2*NBITS-1:0] wr_data_log [16];
    logic [ABITS-1:0]   rda_log [16];
    logic [ABITS-1:0]   rdb_log [16];
    logic [NBITS-1:0]   held_a = '0, held_b = '0;
    always @(posedge clk) begin
        if (bus.wr_en) begin
            wr_addr_log[n_wr[3:0]] <= bus.wr_addr;
            wr_data_log[n_wr[3:0]] <= bus.wr_data;
            n_wr <= n_wr + 1;
        end
        if (bus.rd_en) begin
            rda_log[n_rd[3:0]] <= bus.rd_addr_a;
            rdb_log[n_rd[3:0]] <= bus.rd_addr_b;
            n_rd <= n_rd + 1;
        end
        if (bus.done_p) n_done <= n_done + 1;
        if (bus.rd_en && bus.wr_en) n_overlap <= n_overlap + 1;
        if (bus.mm_enable_p) begin
            n_fire <= n_fire + 1;
            held_a <= bus.mm_a;
            held_b <= bus.mm_b;
        end else if (mbusy && (bus.mm_a !== held_a || bus.mm_b !== held_b)) begin
            n_unstable <= n_unstable + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [ABITS:0] len, input logic [ABITS-1:0] a,
                               input logic [ABITS-1:0] b, input logic [ABITS-1:0] d,
                               input logic nmul);
        bus.len        = len;
        bus.src_a_base = a;
        bus.src_b_base = b;
        bus.dst_base   = d;
        bus.nmul_cfg   = nmul;
        bus.start_p    = 1'b1;
        @(negedge clk);
        bus.start_p    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int limit);
        int k = 0;
        while (n_done == d0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, 256'(n_done > d0), 256'd1);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [ABITS-1:0] addr,
                            input logic [255:0] data);
        check({tag, "_addr"}, 256'(wr_addr_log[idx % 16]), 256'(addr));
        check({tag, "_data"}, wr_data_log[idx % 16], data);
    endtask

    int w0, d0, r0, f0;

    initial begin
        bus.start_p = 1'b0; bus.nmul_cfg = 1'b0; bus.len = '0;
        bus.src_a_base = '0; bus.src_b_base = '0; bus.dst_base = '0;
        mem[12'h010] = 128'd5;  mem[12'h011] = 128'd10; mem[12'h012] = 128'd96; mem[12'h013] = 128'd0;
        mem[12'h020] = 128'd7;  mem[12'h021] = 128'd10; mem[12'h022] = 128'd96; mem[12'h023] = 128'd3;
        mem[12'h030] = '1;      mem[12'h031] = 128'd2;
        mem[12'h040] = 128'd12; mem[12'h041] = 128'd50;
        mem[12'h050] = 128'd9;  mem[12'h051] = 128'd2;
        mem[12'hFFE] = 128'd3;  mem[12'hFFF] = 128'd4;  mem[12'h000] = 128'd5;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", 256'(bus.busy), 256'd0);
        check("rst_done_p", 256'(bus.done_p), 256'd0);
        check("rst_rd_en", 256'(bus.rd_en), 256'd0);
        check("rst_wr_en", 256'(bus.wr_en), 256'd0);
        check("rst_mm_enable", 256'(bus.mm_enable_p), 256'd0);
        check("rst_err", 256'(bus.err_timeout), 256'd0);
        check("rst_mm_a", 256'(bus.mm_a), 256'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: modular product, len=4
        w0 = n_wr; d0 = n_done;
        pulse_start(13'd4, 12'h010, 12'h020, 12'h100, 1'b0);
        check("t1_busy", 256'(bus.busy), 256'd1);
        wait_done("t1_done_seen", d0, 200);
        check("t1_wr_cnt", 256'(n_wr - w0), 256'd4);
        check("t1_done_cnt", 256'(n_done - d0), 256'd1);
        check_wr("t1_w0", w0,     12'h100, 256'd35);
        check_wr("t1_w1", w0 + 1, 12'h101, 256'd3);
        check_wr("t1_w2", w0 + 2, 12'h102, 256'd1);
        check_wr("t1_w3", w0 + 3, 12'h103, 256'd0);
        check("t1_busy_after", 256'(bus.busy), 256'd0);

        // 2: plain product, full width
        w0 = n_wr; d0 = n_done;
        pulse_start(13'd1, 12'h030, 12'h031, 12'h200, 1'b1);
        wait_done("t2_done_seen", d0, 100);
        check("t2_wr_cnt", 256'(n_wr - w0), 256'd1);
        check_wr("t2_w0", w0, 12'h200, 256'h1_ffffffff_ffffffff_ffffffff_fffffffe);
        check("t2_mm_nmul", 256'(bus.mm_nmul), 256'd1);

        // 3: len=0
        w0 = n_wr; d0 = n_done; r0 = n_rd; f0 = n_fire;
        bus.len = '0; bus.nmul_cfg = 1'b0; bus.start_p = 1'b1;
        @(negedge clk);
        bus.start_p = 1'b0;
        check("t3_done_p", 256'(bus.done_p), 256'd1);
        check("t3_busy", 256'(bus.busy), 256'd1);
        @(negedge clk);
        check("t3_done_p_low", 256'(bus.done_p), 256'd0);
        check("t3_busy_low", 256'(bus.busy), 256'd0);
        check("t3_no_rd", 256'(n_rd - r0), 256'd0);
        check("t3_no_fire", 256'(n_fire - f0), 256'd0);
        check("t3_no_wr", 256'(n_wr - w0), 256'd0);
        check("t3_done_cnt", 256'(n_done - d0), 256'd1);

        // 4: re-start while busy, stray done during RD and LOAD
        w0 = n_wr; d0 = n_done;
        pulse_start(13'd2, 12'h040, 12'h050, 12'h300, 1'b0);
        for (int k = 0; k < 20 && !bus.rd_en; k++) @(negedge clk);
        check("t4_in_rd", 256'(bus.rd_en), 256'd1);
        stray_done = 1'b1;
        bus.len = '0; bus.start_p = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stray_done = 1'b0;
        bus.start_p = 1'b0;
        wait_done("t4_done_seen", d0, 200);
        check("t4_wr_cnt", 256'(n_wr - w0), 256'd2);
        check("t4_done_cnt", 256'(n_done - d0), 256'd1);
        check_wr("t4_w0", w0,     12'h300, 256'd11);
        check_wr("t4_w1", w0 + 1, 12'h301, 256'd3);

        // 5a: address wrap
        w0 = n_wr; d0 = n_done; r0 = n_rd;
        pulse_start(13'd3, 12'hFFE, 12'hFFE, 12'hFFE, 1'b0);
        wait_done("t5_done_seen", d0, 200);
        check("t5_rda0", 256'(rda_log[r0 % 16]), 256'h0FFE);
        check("t5_rda1", 256'(rda_log[(r0 + 1) % 16]), 256'h0FFF);
        check("t5_rda2", 256'(rda_log[(r0 + 2) % 16]), 256'h0000);
        check("t5_rdb2", 256'(rdb_log[(r0 + 2) % 16]), 256'h0000);
        check_wr("t5_w0", w0,     12'hFFE, 256'd9);
        check_wr("t5_w1", w0 + 1, 12'hFFF, 256'd16);
        check_wr("t5_w2", w0 + 2, 12'h000, 256'd25);

        // 5b: reset during second element's WAIT
        model_lat = 20;
        w0 = n_wr; d0 = n_done; f0 = n_fire;
        pulse_start(13'd3, 12'hFFE, 12'hFFE, 12'hFFE, 1'b0);
        for (int k = 0; k < 200 && n_fire < f0 + 2; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t5_pre_rst_busy", 256'(bus.busy), 256'd1);
        check("t5_pre_rst_wr", 256'(n_wr - w0), 256'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_busy", 256'(bus.busy), 256'd0);
        check("t5_rst_done_p", 256'(bus.done_p), 256'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_post_wr", 256'(n_wr - w0), 256'd1);
        check("t5_post_done", 256'(n_done - d0), 256'd0);
        check("t5_post_busy", 256'(bus.busy), 256'd0);
        model_lat = 3;

`ifdef MODMUL_VEC_TIMEOUT_EN
        // 6: watchdog
        model_hang = 1'b1;
        w0 = n_wr; d0 = n_done; f0 = n_fire;
        pulse_start(13'd2, 12'h010, 12'h020, 12'h400, 1'b0);
        wait_done("t6_done_seen", d0, 100);
        check("t6_err", 256'(bus.err_timeout), 256'd1);
        check("t6_no_wr", 256'(n_wr - w0), 256'd0);
        check("t6_one_fire", 256'(n_fire - f0), 256'd1);
        repeat (30) @(negedge clk);
        check("t6_done_once", 256'(n_done - d0), 256'd1);
        model_hang = 1'b0;
        w0 = n_wr; d0 = n_done;
        pulse_start(13'd1, 12'h010, 12'h020, 12'h400, 1'b0);
        check("t6_err_cleared", 256'(bus.err_timeout), 256'd0);
        wait_done("t6b_done_seen", d0, 100);
        check_wr("t6b_w0", w0, 12'h400, 256'd35);
`else
        check("err_tied_low", 256'(bus.err_timeout), 256'd0);
`endif

        check("no_rd_wr_overlap", 256'(n_overlap), 256'd0);
        check("operands_stable", 256'(n_unstable), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
